i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter OWN_ADR, default 7'h42: reset value of the ADR register.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth on scl_i/sda_i (allowed 2..3).
REQ-003 SHALL have port clk_i  input  1  system clock; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port rst_ni  input  1  synchronous active-low reset.
REQ-005 SHALL have port write_i  input  1  register-bus write strobe.
REQ-006 SHALL have port data_be_i  input  4  byte enables; lane i maps to byte address addr_i+i.
REQ-007 SHALL have port addr_i  input  5  register-bus byte address.
REQ-008 SHALL have port wdata_i  input  32  write data; lane i is wdata_i[8i+7:8i].
REQ-009 SHALL have port rdata_o  output  32  combinational read data; lanes with data_be_i[i]=0 read 0.
REQ-010 SHALL have port scl_i  input  1  I2C clock pin, asynchronous.
REQ-011 SHALL have port sda_i  input  1  I2C data pin, asynchronous.
REQ-012 SHALL have port sda_oe_o  output  1  1 = pull SDA low; 0 = release.

Function
REQ-013 SHALL map registers: 0x00 ADR[6:0] (RW); 0x04-0x07 RXD (RO); 0x08-0x0B TXD (RW); 0x0C STS (RW1C bits 3-4); other bytes read 0 and ignore writes.
REQ-014 SHALL define STS: [2:0] RXCNT (0-4), [3] RX_DONE, [4] TX_DONE, [5] BUSY, [6] OVF; bits 7+ read 0.
REQ-015 SHALL decode writes per byte lane when write_i=1, lane address = addr_i+i, lane enabled by data_be_i[i].
REQ-016 SHALL synchronize scl_i/sda_i through SYNC_STAGES flops, then register once more for edge detection.
REQ-017 SHALL detect START as synchronized SDA falling while SCL high, STOP as SDA rising while SCL high.
REQ-018 SHALL sample SDA on synchronized SCL rising edge; SHALL update sda_oe_o on the clk_i cycle after a synchronized SCL falling edge.
REQ-019 SHALL implement states IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
REQ-020 SHALL, on START in any state (including repeated START), enter ADDR, clear the bit counter, set BUSY.
REQ-021 SHALL, on STOP in any state, enter IDLE, release SDA, clear BUSY; set RX_DONE if the transaction was an addressed write, TX_DONE if an addressed read.
REQ-022 SHALL, in ADDR, shift 8 bits MSB first; bits [7:1] are the address, bit 0 is R/W (1 = read).
REQ-023 SHALL, on address match, go to ADDR_ACK and drive SDA low for one SCL period; on write also clear RXCNT, OVF and RXD.
REQ-024 SHALL, on address mismatch, release SDA and go to WAIT_STOP.
REQ-025 SHALL, after ADDR_ACK, go to RX (write) or TX (read).
REQ-026 SHALL, in RX, shift 8 bits MSB first into RXD byte RXCNT, increment RXCNT, then ACK in RX_ACK and return to RX.
REQ-027 SHALL, when a 5th byte arrives (RXCNT=4), discard it, set OVF, NACK it (release SDA), and go to WAIT_STOP.
REQ-028 SHALL, in TX, load TXD byte k at the start of byte k (k=0..3), drive it MSB first (drive low for 0, release for 1); for k>=4 send 8'hFF.
REQ-029 SHALL, in TX_ACK, release SDA and sample the master's bit: 0 -> TX with k+1; 1 (NACK) -> WAIT_STOP.
REQ-030 SHALL NOT stretch SCL.
REQ-031 SHALL give a hardware set of RX_DONE/TX_DONE priority over a same-cycle W1C clear.
REQ-032 SHALL accept TXD writes at any time; a byte already loaded into the shifter is unaffected.
REQ-033 SHALL accept ADR writes at any time; the new value takes effect at the next address-byte comparison.

Reset
REQ-034 SHALL, when rst_ni=0 at a clk_i edge, set state IDLE, sda_oe_o=0, ADR=OWN_ADR, RXD=0, TXD=0, STS=0, synchronizer flops=1.
REQ-035 SHALL, on reset mid-transaction, abandon it and ignore the bus until the next START.

Verification
REQ-036 SHALL cover: write to 0x42 with bytes A5,3C, then STOP -> both ACKed; RXD=0x00003CA5, RXCNT=2, RX_DONE=1.
REQ-037 SHALL cover: TXD=0x11223344, read from 0x42 of 2 bytes (master ACK, then NACK) -> SDA carries 0x44,0x33; TX_DONE=1 after STOP.
REQ-038 SHALL cover: address 0x43 -> address byte NACKed, sda_oe_o stays 0 until STOP, STS unchanged.
REQ-039 SHALL cover: 5-byte write -> 4 ACKs, 5th NACKed; RXCNT=4, OVF=1, RXD holds the first 4 bytes.
REQ-040 SHALL cover: write 1 byte, then repeated START as read -> RXD byte0 kept, TXD byte0 sent, only TX_DONE set at STOP.
REQ-041 SHALL cover: rst_ni=0 during RX bit 4 -> sda_oe_o=0 next cycle, STS=0; next full write transaction is ACKed normally.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target with a small byte-addressed register window: 7-bit own address,
// four-byte receive and transmit buffers, and a status register with W1C done flags.
module i2c_target #(
    parameter logic [6:0]  OWN_ADR     = 7'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        write_i,
    input  logic [3:0]  data_be_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe_o
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
    } state_t;

    typedef enum logic [1:0] {XFER_NONE, XFER_WR, XFER_RD} xfer_t;

    state_t state, state_n;
    xfer_t  xfer;
    logic   oe_n;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_q, sda_q;
    logic start_det, stop_det, scl_rise, scl_fall;

    logic [6:0]      adr, adr_n;
    logic [3:0][7:0] rxd, txd, txd_n;
    logic [2:0]      rxcnt;
    logic            rx_done, tx_done, busy, ovf;
    logic            w1c_rx, w1c_tx;

    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [7:0] tx_sh, byte_in, tx_byte;
    logic [2:0] tx_idx;
    logic       last_bit, addr_hit;
    logic [5:0] lane_addr [4];

    // Synchronizers idle high so reset never manufactures a START or STOP.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_q    <= scl_sync[SYNC_STAGES-1];
            sda_q    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;

    assign byte_in  = {shreg, sda_s};
    assign last_bit = (bit_cnt == 3'd7);
    assign addr_hit = (byte_in[7:1] == adr);
    assign tx_byte  = tx_idx[2] ? 8'hFF : txd[tx_idx[1:0]];

    always_comb begin
        for (int i = 0; i < 4; i++) lane_addr[i] = {1'b0, addr_i} + 6'(i);
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        adr_n  = adr;
        txd_n  = txd;
        w1c_rx = 1'b0;
        w1c_tx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (write_i && data_be_i[i]) begin
                case (lane_addr[i])
                    6'h00: adr_n = wdata_i[8*i +: 7];
                    6'h08, 6'h09, 6'h0A, 6'h0B:
                        txd_n[lane_addr[i][1:0]] = wdata_i[8*i +: 8];
                    6'h0C: begin
                        w1c_rx = wdata_i[8*i+3];
                        w1c_tx = wdata_i[8*i+4];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < 4; i++) begin
            if (data_be_i[i]) begin
                case (lane_addr[i])
                    6'h00: rdata_o[8*i +: 8] = {1'b0, adr};
                    6'h04, 6'h05, 6'h06, 6'h07:
                        rdata_o[8*i +: 8] = rxd[lane_addr[i][1:0]];
                    6'h08, 6'h09, 6'h0A, 6'h0B:
                        rdata_o[8*i +: 8] = txd[lane_addr[i][1:0]];
                    6'h0C: rdata_o[8*i +: 8] = {1'b0, ovf, busy, tx_done, rx_done, rxcnt};
                    default: rdata_o[8*i +: 8] = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            sda_oe_o <= 1'b0;
        end else begin
            state    <= state_n;
            sda_oe_o <= oe_n;
        end
    end

    // SDA is only ever changed on an SCL fall, so data is stable while SCL is high.
    always_comb begin
        state_n = state;
        oe_n    = sda_oe_o;
        if (start_det) begin
            state_n = ADDR;
            oe_n    = 1'b0;
        end else if (stop_det) begin
            state_n = IDLE;
            oe_n    = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise && last_bit) state_n = addr_hit ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK: begin
                    if (scl_fall) oe_n = 1'b1;
                    if (scl_rise) state_n = (xfer == XFER_RD) ? TX : RX;
                end
                RX: begin
                    if (scl_fall) oe_n = 1'b0;
                    if (scl_rise && last_bit) state_n = (rxcnt == 3'd4) ? WAIT_STOP : RX_ACK;
                end
                RX_ACK: begin
                    if (scl_fall) oe_n = 1'b1;
                    if (scl_rise) state_n = RX;
                end
                TX: begin
                    if (scl_fall) oe_n = (bit_cnt == 3'd0) ? ~tx_byte[7] : ~tx_sh[7];
                    if (scl_rise && last_bit) state_n = TX_ACK;
                end
                TX_ACK: begin
                    if (scl_fall) oe_n = 1'b0;
                    if (scl_rise) state_n = sda_s ? WAIT_STOP : TX;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the RXD/TXD byte buffers are reset because software reads them as registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            adr     <= OWN_ADR;
            txd     <= '0;
            rxd     <= '0;
            rxcnt   <= '0;
            ovf     <= 1'b0;
            rx_done <= 1'b0;
            tx_done <= 1'b0;
            busy    <= 1'b0;
            xfer    <= XFER_NONE;
            bit_cnt <= '0;
            shreg   <= '0;
            tx_sh   <= '0;
            tx_idx  <= '0;
        end else begin
            adr     <= adr_n;
            txd     <= txd_n;
            rx_done <= (stop_det && xfer == XFER_WR) | (rx_done & ~w1c_rx);
            tx_done <= (stop_det && xfer == XFER_RD) | (tx_done & ~w1c_tx);
            if (start_det) begin
                bit_cnt <= '0;
                busy    <= 1'b1;
                xfer    <= XFER_NONE;
            end else if (stop_det) begin
                busy <= 1'b0;
                xfer <= XFER_NONE;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shreg   <= byte_in[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit && addr_hit) begin
                            xfer   <= byte_in[0] ? XFER_RD : XFER_WR;
                            tx_idx <= '0;
                            if (!byte_in[0]) begin
                                rxcnt <= '0;
                                ovf   <= 1'b0;
                                rxd   <= '0;
                            end
                        end
                    end
                    RX: if (scl_rise) begin
                        shreg   <= byte_in[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            if (rxcnt == 3'd4) begin
                                ovf <= 1'b1;
                            end else begin
                                rxd[rxcnt[1:0]] <= byte_in;
                                rxcnt           <= rxcnt + 3'd1;
                            end
                        end
                    end
                    TX: begin
                        if (scl_fall)
                            tx_sh <= (bit_cnt == 3'd0) ? {tx_byte[6:0], 1'b1} : {tx_sh[6:0], 1'b1};
                        if (scl_rise) bit_cnt <= bit_cnt + 3'd1;
                    end
                    TX_ACK: if (scl_rise) begin
                        bit_cnt <= '0;
                        if (!sda_s && !tx_idx[2]) tx_idx <= tx_idx + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: a bit-banged I2C master plus a
// transaction-level model of the register file and bus responses.
module tb_i2c_target;

    localparam int Q = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write;
    logic [3:0]  data_be;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        scl_m, sda_m, sda_oe;
    logic        sda_line;

    int checks   = 0;
    int failures = 0;

    logic [6:0] m_adr;
    logic [7:0] m_txd [4];
    logic [7:0] m_rxd [4];
    int         m_rxcnt;
    bit         m_rxdone, m_txdone, m_ovf;
    int         m_xfer;
    logic [7:0] wq [8];

    logic mon_en = 1'b0;
    logic oe_seen = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target #(.OWN_ADR(7'h42), .SYNC_STAGES(2)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .write_i  (write),
        .data_be_i(data_be),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .rdata_o  (rdata),
        .scl_i    (scl_m),
        .sda_i    (sda_line),
        .sda_oe_o (sda_oe)
    );

    always @(negedge clk) begin
        if (!mon_en) oe_seen <= 1'b0;
        else if (sda_oe) oe_seen <= 1'b1;
    end

    initial begin
        #1500us;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_adr = 7'h42;
        for (int i = 0; i < 4; i++) begin
            m_txd[i] = 8'h00;
            m_rxd[i] = 8'h00;
        end
        m_rxcnt = 0; m_rxdone = 0; m_txdone = 0; m_ovf = 0; m_xfer = 0;
    endtask

    function automatic logic [7:0] m_byte(input int a);
        if (a == 0) return {1'b0, m_adr};
        if (a >= 4 && a <= 7) return m_rxd[a-4];
        if (a >= 8 && a <= 11) return m_txd[a-8];
        if (a == 12) return {1'b0, m_ovf, 1'b0, m_txdone, m_rxdone, 3'(m_rxcnt)};
        return 8'h00;
    endfunction

    function automatic logic [31:0] m_word(input int a, input logic [3:0] be);
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = m_byte(a + i);
        return w;
    endfunction

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic reg_write(input int a, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk);
        addr = 5'(a); data_be = be; wdata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0; data_be = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                int ai = a + i;
                if (ai == 0) m_adr = d[8*i +: 7];
                else if (ai >= 8 && ai <= 11) m_txd[ai-8] = d[8*i +: 8];
                else if (ai == 12) begin
                    if (d[8*i+3]) m_rxdone = 0;
                    if (d[8*i+4]) m_txdone = 0;
                end
            end
        end
    endtask

    task automatic reg_read(input int a, input logic [3:0] be, output logic [31:0] d);
        @(negedge clk);
        addr = 5'(a); data_be = be; write = 1'b0;
        #1 d = rdata;
    endtask

    task automatic check_reg(input string tag, input int a, input logic [3:0] be);
        logic [31:0] d;
        reg_read(a, be, d);
        check(tag, d, m_word(a, be));
    endtask

    task automatic check_all();
        check_reg("adr", 0, 4'hF);
        check_reg("rxd", 4, 4'hF);
        check_reg("txd", 8, 4'hF);
        check_reg("sts", 12, 4'hF);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b; wait_q();
        scl_m = 1'b1; wait_q();
        s = sda_line;
        scl_m = 1'b0; wait_q();
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic rd_byte(output logic [7:0] b, input logic mack);
        logic s;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, s);
            b = {b[6:0], s};
        end
        clk_bit(~mack, s);
    endtask

    task automatic m_write_txn(input logic [6:0] a, input int n, input bit rep);
        logic ack;
        bit   hit, exp;
        if (rep) i2c_rstart(); else i2c_start();
        m_xfer = 0;
        wr_byte({a, 1'b0}, ack);
        hit = (a == m_adr);
        check("wr_addr_ack", ack, hit);
        if (hit) begin
            m_xfer = 1; m_rxcnt = 0; m_ovf = 0;
            for (int i = 0; i < 4; i++) m_rxd[i] = 8'h00;
            for (int i = 0; i < n; i++) begin
                wr_byte(wq[i], ack);
                exp = (m_rxcnt < 4);
                check("wr_data_ack", ack, exp);
                if (exp) begin
                    m_rxd[m_rxcnt] = wq[i];
                    m_rxcnt++;
                end else begin
                    m_ovf = 1;
                    break;
                end
            end
        end
    endtask

    task automatic m_read_txn(input logic [6:0] a, input int n, input bit rep);
        logic       ack;
        logic [7:0] b;
        bit         hit;
        if (rep) i2c_rstart(); else i2c_start();
        m_xfer = 0;
        wr_byte({a, 1'b1}, ack);
        hit = (a == m_adr);
        check("rd_addr_ack", ack, hit);
        if (hit) begin
            m_xfer = 2;
            for (int i = 0; i < n; i++) begin
                rd_byte(b, i < n - 1);
                check("rd_data", b, (i < 4) ? m_txd[i] : 8'hFF);
            end
        end
    endtask

    task automatic m_stop();
        i2c_stop();
        if (m_xfer == 1) m_rxdone = 1;
        if (m_xfer == 2) m_txdone = 1;
        m_xfer = 0;
    endtask

    initial begin
        logic [31:0] d;
        logic        s, ack;
        scl_m = 1'b1; sda_m = 1'b1; write = 1'b0; data_be = 4'h0; addr = '0; wdata = '0;
        rst_n = 1'b0;
        m_reset();
        repeat (4) @(negedge clk);
        check("oe_reset", sda_oe, 1'b0);
        check_all();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Two-byte write.
        wq[0] = 8'hA5; wq[1] = 8'h3C;
        m_write_txn(7'h42, 2, 0);
        m_stop();
        check_all();
        reg_read(4, 4'hF, d);  check("rxd_a53c", d, 32'h0000_3CA5);
        reg_read(12, 4'hF, d); check("sts_wr", d, 32'h0000_000A);
        reg_write(12, 4'b0001, 32'h0000_00FF);
        check_reg("sts_w1c", 12, 4'hF);

        // Two-byte read of a preloaded TXD.
        reg_write(8, 4'hF, 32'h1122_3344);
        m_read_txn(7'h42, 2, 0);
        m_stop();
        check_all();
        reg_read(12, 4'hF, d); check("sts_rd", d, 32'h0000_0012);

        // Address mismatch: never drives, status unchanged.
        reg_write(12, 4'b0001, 32'h18);
        mon_en = 1'b1;
        wq[0] = 8'h55;
        m_write_txn(7'h43, 1, 0);
        m_stop();
        check("nack_oe_quiet", oe_seen, 1'b0);
        mon_en = 1'b0;
        check_all();

        // Five-byte write overflows.
        for (int i = 0; i < 5; i++) wq[i] = 8'($urandom);
        m_write_txn(7'h42, 5, 0);
        m_stop();
        check_all();

        // Write then repeated START as read.
        reg_write(12, 4'b0001, 32'h18);
        wq[0] = 8'($urandom);
        m_write_txn(7'h42, 1, 0);
        m_read_txn(7'h42, 1, 1);
        m_stop();
        check_all();
        reg_read(12, 4'hF, d); check("sts_rstart_flags", d[4:3], 2'b10);

        // Address change takes effect on the next address byte.
        reg_write(0, 4'b0001, 32'h0000_0097);
        wq[0] = 8'($urandom); wq[1] = 8'($urandom);
        m_write_txn(7'h42, 1, 0);
        m_stop();
        m_write_txn(7'h17, 2, 0);
        m_stop();
        check_all();

        // Misaligned lanes, read-only and unmapped writes.
        reg_write(9, 4'b0110, $urandom);
        reg_write(4, 4'hF, $urandom);
        reg_write(16, 4'hF, $urandom);
        check_reg("lane_rd_5", 5, 4'b0111);
        check_reg("lane_rd_10", 10, 4'hF);
        check_all();
        reg_write(0, 4'b0001, 32'h42);

        // Reset in the middle of a received byte.
        reg_write(12, 4'b0001, 32'h18);
        i2c_start();
        wr_byte({7'h42, 1'b0}, ack);
        check("rst_addr_ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) clk_bit(1'($urandom), s);
        reg_read(12, 4'hF, d); check("sts_busy_mid", d, 32'h0000_0020);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        check("oe_after_rst", sda_oe, 1'b0);
        m_reset();
        check_all();
        rst_n = 1'b1;
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        for (int i = 0; i < 3; i++) wq[i] = 8'($urandom);
        m_write_txn(7'h42, 3, 0);
        m_stop();
        check_all();

        // Randomized transactions against the model.
        for (int it = 0; it < 12; it++) begin
            int         kind = $urandom_range(0, 2);
            int         n    = $urandom_range(1, 6);
            logic [6:0] a    = ($urandom_range(0, 3) == 0) ? 7'($urandom) : m_adr;
            if ($urandom_range(0, 1) == 1) reg_write(12, 4'b0001, 32'h18);
            if (kind == 2) reg_write(8, 4'($urandom), $urandom);
            for (int i = 0; i < 8; i++) wq[i] = 8'($urandom);
            if (kind == 0) m_write_txn(a, n, 0);
            else           m_read_txn(a, n, 0);
            m_stop();
            check_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
